// File: rtl/core_pkg.sv
// Shared core definitions: datapath width, PC generator states and default vectors.
package core_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    PC_BOOT = 2'd0,
    PC_RUN  = 2'd1,
    PC_HOLD = 2'd2
  } pc_state_e;

  localparam logic [XLEN-1:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam logic [XLEN-1:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0100;

endpackage

// File: rtl/pc_gen.sv
// Program-counter generator feeding fetch: advance, redirect and stall-deferred redirect.
// Optional macro PC_MISALIGN_TRAP_EN traps misaligned redirect targets to TRAP_VECTOR.
import core_pkg::*;

module pc_gen #(
  parameter logic [XLEN-1:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
`ifdef PC_MISALIGN_TRAP_EN
  ,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = DEFAULT_TRAP_VECTOR
`endif
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            fetch_ready_i,
  input  logic            stall_i,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_target_i,
  output logic [XLEN-1:0] pc_o,
  output logic            pc_valid_o,
  output logic [XLEN-1:0] pc_plus4_o
`ifdef PC_MISALIGN_TRAP_EN
  ,
  output logic            misalign_o,
  output logic [XLEN-1:0] bad_target_o
`endif
);

  pc_state_e       r_state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_pending;
  logic            r_pendingValid;

  logic [XLEN-1:0] w_srcTarget;
  logic [XLEN-1:0] w_loadPc;
  logic            w_load;
  logic            w_adv;
  logic            w_misaligned;

  // A fresh redirect always beats a stored one; pending is only consumed when none arrives.
  assign w_srcTarget = redirect_valid_i ? redirect_target_i : r_pending;

  assign w_load = ((r_state == PC_BOOT) && redirect_valid_i) ||
                  ((r_state == PC_RUN)  && redirect_valid_i && !stall_i) ||
                  ((r_state == PC_HOLD) && !stall_i && (redirect_valid_i || r_pendingValid));

  assign w_adv = (r_state == PC_RUN) && pc_valid_o && fetch_ready_i && !stall_i;

`ifdef PC_MISALIGN_TRAP_EN
  assign w_misaligned = (w_srcTarget[1:0] != 2'b00);
  assign w_loadPc     = w_misaligned ? TRAP_VECTOR : w_srcTarget;
`else
  assign w_misaligned = 1'b0;
  assign w_loadPc     = w_srcTarget & ~32'h0000_0003;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= PC_BOOT;
      r_pc           <= RESET_VECTOR;
      r_pending      <= '0;
      r_pendingValid <= 1'b0;
    end else begin
      case (r_state)
        PC_BOOT: begin
          r_state        <= PC_RUN;
          r_pendingValid <= 1'b0;
          if (w_load) r_pc <= w_loadPc;
        end
        PC_RUN: begin
          if (w_load) begin
            r_pc <= w_loadPc;
          end else if (redirect_valid_i && stall_i) begin
            r_pending      <= redirect_target_i;
            r_pendingValid <= 1'b1;
            r_state        <= PC_HOLD;
          end else if (w_adv) begin
            r_pc <= r_pc + 32'd4;
          end
        end
        PC_HOLD: begin
          if (!stall_i) begin
            if (w_load) r_pc <= w_loadPc;
            r_pendingValid <= 1'b0;
            r_state        <= PC_RUN;
          end else if (redirect_valid_i) begin
            r_pending <= redirect_target_i;
          end
        end
        default: begin
          r_state <= PC_BOOT;
        end
      endcase
    end
  end

`ifdef PC_MISALIGN_TRAP_EN
  logic            r_misalign;
  logic [XLEN-1:0] r_badTarget;

  // Pulse lines up with the cycle pc_o shows TRAP_VECTOR; bad target sticks until the next trap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_misalign  <= 1'b0;
      r_badTarget <= '0;
    end else begin
      r_misalign <= w_load && w_misaligned;
      if (w_load && w_misaligned) r_badTarget <= w_srcTarget;
    end
  end

  assign misalign_o   = r_misalign;
  assign bad_target_o = r_badTarget;
`else
  logic w_unusedMisaligned;
  assign w_unusedMisaligned = w_misaligned;
`endif

  assign pc_o       = r_pc;
  assign pc_valid_o = (r_state != PC_BOOT);
  assign pc_plus4_o = r_pc + 32'd4;

endmodule

// File: tb/tb_pc_gen.sv
// Directed self-checking bench for pc_gen; follows PC_MISALIGN_TRAP_EN if defined.
module tb_pc_gen;

  logic        clk;
  logic        resetN;
  logic        fetchReady;
  logic        stall;
  logic        redirectValid;
  logic [31:0] redirectTarget;
  logic [31:0] pc;
  logic        pcValid;
  logic [31:0] pcPlus4;
`ifdef PC_MISALIGN_TRAP_EN
  logic        misalign;
  logic [31:0] badTarget;
  localparam logic [31:0] MIS_PC = 32'h0000_0100;
`else
  localparam logic [31:0] MIS_PC = 32'h0000_0200;
`endif

  int checks   = 0;
  int failures = 0;

  pc_gen dut (
    .clk               (clk),
    .reset_n           (resetN),
    .fetch_ready_i     (fetchReady),
    .stall_i           (stall),
    .redirect_valid_i  (redirectValid),
    .redirect_target_i (redirectTarget),
    .pc_o              (pc),
    .pc_valid_o        (pcValid),
    .pc_plus4_o        (pcPlus4)
`ifdef PC_MISALIGN_TRAP_EN
    ,
    .misalign_o        (misalign),
    .bad_target_o      (badTarget)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Sets inputs, then advances one clock and settles 1ns past the edge.
  task automatic applyStimulus(input logic rdy, input logic stl, input logic rv, input logic [31:0] tgt);
    fetchReady     = rdy;
    stall          = stl;
    redirectValid  = rv;
    redirectTarget = tgt;
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetN = 1'b0; fetchReady = 1'b1; stall = 1'b0; redirectValid = 1'b0; redirectTarget = '0;
    #12;
    checkOutput("reset_pc", pc, 32'h0);
    checkOutput("reset_valid", {31'b0, pcValid}, 32'h0);

    // Reset release and sequential fetch
    @(posedge clk); #1; resetN = 1'b1;
    checkOutput("boot_valid", {31'b0, pcValid}, 32'h0);
    applyStimulus(1, 0, 0, 0);
    checkOutput("c1_pc", pc, 32'h0);
    checkOutput("c1_valid", {31'b0, pcValid}, 32'h1);
    applyStimulus(1, 0, 0, 0);
    checkOutput("c2_pc", pc, 32'h4);
    applyStimulus(1, 0, 0, 0);
    checkOutput("c3_pc", pc, 32'h8);
    checkOutput("c3_plus4", pcPlus4, 32'hC);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0);
    checkOutput("run_pc10", pc, 32'h10);

    // Redirect without fetch_ready
    applyStimulus(0, 0, 1, 32'h200);
    checkOutput("redir_pc", pc, 32'h200);
    applyStimulus(1, 0, 0, 0);
    checkOutput("redir_next", pc, 32'h204);

    // Stall with two redirects; latest wins
    applyStimulus(1, 1, 0, 0);
    checkOutput("stall0_pc", pc, 32'h204);
    applyStimulus(1, 1, 1, 32'h300);
    checkOutput("stall1_pc", pc, 32'h204);
    applyStimulus(1, 1, 1, 32'h400);
    checkOutput("stall2_pc", pc, 32'h204);
    checkOutput("hold_valid", {31'b0, pcValid}, 32'h1);
    applyStimulus(1, 0, 0, 0);
    checkOutput("unstall_pc", pc, 32'h400);
    applyStimulus(1, 0, 0, 0);
    checkOutput("unstall_next", pc, 32'h404);

    // Wrap at top of address space
    applyStimulus(0, 0, 1, 32'hFFFF_FFFC);
    checkOutput("top_pc", pc, 32'hFFFF_FFFC);
    checkOutput("top_plus4", pcPlus4, 32'h0);
    applyStimulus(1, 0, 0, 0);
    checkOutput("wrap_pc", pc, 32'h0);
    checkOutput("wrap_plus4", pcPlus4, 32'h4);

    // Misaligned redirect
    applyStimulus(0, 0, 1, 32'h202);
    checkOutput("mis_pc", pc, MIS_PC);
`ifdef PC_MISALIGN_TRAP_EN
    checkOutput("mis_pulse", {31'b0, misalign}, 32'h1);
    checkOutput("mis_bad", badTarget, 32'h202);
`endif
    applyStimulus(0, 0, 0, 0);
    checkOutput("mis_hold", pc, MIS_PC);
`ifdef PC_MISALIGN_TRAP_EN
    checkOutput("mis_pulse_end", {31'b0, misalign}, 32'h0);
    checkOutput("mis_bad_hold", badTarget, 32'h202);
`endif

    // New redirect on the unstall cycle beats the pending one
    applyStimulus(0, 1, 1, 32'h500);
    checkOutput("hold500_pc", pc, MIS_PC);
    applyStimulus(0, 0, 1, 32'h600);
    checkOutput("newwins_pc", pc, 32'h600);
    applyStimulus(0, 0, 0, 0);
    checkOutput("idle_pc", pc, 32'h600);

    // Reset while holding a pending redirect
    applyStimulus(0, 1, 1, 32'h700);
    checkOutput("hold700_pc", pc, 32'h600);
    redirectValid = 1'b0;
    #3 resetN = 1'b0;
    #1;
    checkOutput("async_rst_pc", pc, 32'h0);
    checkOutput("async_rst_valid", {31'b0, pcValid}, 32'h0);
    stall = 1'b0; fetchReady = 1'b1;
    @(posedge clk); #1; resetN = 1'b1;
    checkOutput("reboot_valid", {31'b0, pcValid}, 32'h0);
    applyStimulus(1, 0, 0, 0);
    checkOutput("reboot_pc0", pc, 32'h0);
    applyStimulus(1, 0, 0, 0);
    checkOutput("reboot_pc4", pc, 32'h4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
